exu_alu_ibuf: RTL and testbench

Receive-side buffer for the dispatch-to-ALU valid/ready channel. It sits at the ALU end of the dispatch interface and accepts the dispatched operation bundle (masked operands, rd control, decode info, immediate, PC) into a small FIFO. It presents the oldest entry to the ALU datapath. Its ready output comes from a register, which breaks the combinational ready path from ALU back through dispatch. A flush input discards all buffered operations.

---
 rtl/exu_alu_ibuf.sv | 111 +++++++++++
 tb/tb_exu_alu_ibuf.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_alu_ibuf.sv
// Receive-side FIFO for the dispatch-to-ALU channel.
// The input-side ready comes from a flop, so the ALU's ready never feeds back to dispatch.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
`ifndef DECINFO_WIDTH
`define DECINFO_WIDTH 32
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

module exu_alu_ibuf #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      ibuf_i_valid,
    output logic                      ibuf_i_ready,
    input  logic [`XLEN-1:0]          ibuf_i_rs1,
    input  logic [`XLEN-1:0]          ibuf_i_rs2,
    input  logic                      ibuf_i_rdwen,
    input  logic [`RFIDX_WIDTH-1:0]   ibuf_i_rdidx,
    input  logic [`DECINFO_WIDTH-1:0] ibuf_i_info,
    input  logic [`XLEN-1:0]          ibuf_i_imm,
    input  logic [`PC_SIZE-1:0]       ibuf_i_pc,
    output logic                      ibuf_o_valid,
    input  logic                      ibuf_o_ready,
    output logic [`XLEN-1:0]          ibuf_o_rs1,
    output logic [`XLEN-1:0]          ibuf_o_rs2,
    output logic                      ibuf_o_rdwen,
    output logic [`RFIDX_WIDTH-1:0]   ibuf_o_rdidx,
    output logic [`DECINFO_WIDTH-1:0] ibuf_o_info,
    output logic [`XLEN-1:0]          ibuf_o_imm,
    output logic [`PC_SIZE-1:0]       ibuf_o_pc,
    output logic [CW-1:0]             ibuf_o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 3 * `XLEN + 1 + `RFIDX_WIDTH + `DECINFO_WIDTH + `PC_SIZE;

    logic [EW-1:0] ent_q [DEPTH];
    logic [EW-1:0] ent_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdy_q, rdy_d;
    logic          push, pop;
    logic [EW-1:0] head;

    assign ibuf_i_ready = rdy_q;
    assign ibuf_o_valid = (cnt_q != '0);
    assign ibuf_o_count = cnt_q;
    assign push         = ibuf_i_valid & rdy_q & ~flush;
    assign pop          = ibuf_o_valid & ibuf_o_ready & ~flush;
    assign head         = ent_q[rptr_q];
    assign {ibuf_o_rs1, ibuf_o_rs2, ibuf_o_rdwen, ibuf_o_rdidx,
            ibuf_o_info, ibuf_o_imm, ibuf_o_pc} = head;

    always_comb begin
        ent_d  = ent_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            // Storage is left as-is; only the bookkeeping is discarded.
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) begin
                ent_d[wptr_q] = {ibuf_i_rs1, ibuf_i_rs2, ibuf_i_rdwen, ibuf_i_rdidx,
                                 ibuf_i_info, ibuf_i_imm, ibuf_i_pc};
                wptr_d = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
        // Derived from next occupancy so a pop while full reopens the input one cycle later.
        rdy_d = (cnt_d < CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            rdy_q  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            rdy_q  <= rdy_d;
            ent_q  <= ent_d;
        end
    end

endmodule

// File: tb/tb_exu_alu_ibuf.sv
// Bench for exu_alu_ibuf: queue-based reference model checked every cycle,
// a vector table for fill/backpressure/flush, and hand sequences for reset, hold and streaming.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
`ifndef DECINFO_WIDTH
`define DECINFO_WIDTH 32
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

module tb_exu_alu_ibuf;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [`XLEN-1:0]          rs1;
        logic [`XLEN-1:0]          rs2;
        logic                      rdwen;
        logic [`RFIDX_WIDTH-1:0]   rdidx;
        logic [`DECINFO_WIDTH-1:0] info;
        logic [`XLEN-1:0]          imm;
        logic [`PC_SIZE-1:0]       pc;
    } pl_t;

    typedef struct {
        logic        v;
        logic        ordy;
        logic        fl;
        logic [31:0] pc;
        int          cnt;
        logic        irdy;
        logic        ovld;
        logic [31:0] hpc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic iv = 1'b0;
    logic ordy = 1'b0;
    logic [`XLEN-1:0]          i_rs1 = '0, i_rs2 = '0, i_imm = '0;
    logic                      i_rdwen = 1'b0;
    logic [`RFIDX_WIDTH-1:0]   i_rdidx = '0;
    logic [`DECINFO_WIDTH-1:0] i_info = '0;
    logic [`PC_SIZE-1:0]       i_pc = '0;
    logic                      iready, ovalid, o_rdwen;
    logic [`XLEN-1:0]          o_rs1, o_rs2, o_imm;
    logic [`RFIDX_WIDTH-1:0]   o_rdidx;
    logic [`DECINFO_WIDTH-1:0] o_info;
    logic [`PC_SIZE-1:0]       o_pc;
    logic [CW-1:0]             ocount;

    int   n_vec = 0;
    int   n_err = 0;
    int   pops = 0;
    pl_t  q[$];
    logic rdy_m = 1'b1;
    logic mdl_init = 1'b0;

    exu_alu_ibuf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ibuf_i_valid(iv), .ibuf_i_ready(iready),
        .ibuf_i_rs1(i_rs1), .ibuf_i_rs2(i_rs2), .ibuf_i_rdwen(i_rdwen),
        .ibuf_i_rdidx(i_rdidx), .ibuf_i_info(i_info), .ibuf_i_imm(i_imm), .ibuf_i_pc(i_pc),
        .ibuf_o_valid(ovalid), .ibuf_o_ready(ordy),
        .ibuf_o_rs1(o_rs1), .ibuf_o_rs2(o_rs2), .ibuf_o_rdwen(o_rdwen),
        .ibuf_o_rdidx(o_rdidx), .ibuf_o_info(o_info), .ibuf_o_imm(o_imm), .ibuf_o_pc(o_pc),
        .ibuf_o_count(ocount)
    );

    always #5 clk = ~clk;

    function automatic pl_t cur_in();
        return '{rs1: i_rs1, rs2: i_rs2, rdwen: i_rdwen, rdidx: i_rdidx,
                 info: i_info, imm: i_imm, pc: i_pc};
    endfunction

    function automatic pl_t cur_out();
        return '{rs1: o_rs1, rs2: o_rs2, rdwen: o_rdwen, rdidx: o_rdidx,
                 info: o_info, imm: o_imm, pc: o_pc};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_pl(input string name, input pl_t got, input pl_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic set_op(input logic [31:0] pc);
        i_pc    = pc;
        i_rs1   = pc ^ 32'h1234_5678;
        i_rs2   = ~pc;
        i_rdwen = pc[2];
        i_rdidx = pc[6:2];
        i_info  = `DECINFO_WIDTH'(pc * 3);
        i_imm   = pc + 32'h10;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: predicts the next edge from inputs sampled mid-cycle.
    always @(negedge clk) begin
        logic do_pop, do_push;
        if (mdl_init) begin
            chk("o_valid", 64'(ovalid), 64'(q.size() != 0));
            chk("count", 64'(ocount), 64'(q.size()));
            chk("i_ready", 64'(iready), 64'(rdy_m));
            if (q.size() != 0) chk_pl("head", cur_out(), q[0]);
        end
        if (rst || flush) begin
            q.delete();
            rdy_m    = 1'b1;
            mdl_init = 1'b1;
        end else if (mdl_init) begin
            do_pop  = (q.size() != 0) && ordy;
            do_push = iv && rdy_m;
            if (do_pop) begin
                void'(q.pop_front());
                pops++;
            end
            if (do_push) q.push_back(cur_in());
            rdy_m = (q.size() < DEPTH);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[13];
        int   p0;
        logic [31:0] hold_pc;

        //      v     ordy  fl    pc          cnt irdy  ovld  head pc
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h100, 1, 1'b1, 1'b1, 32'h100};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h104, 2, 1'b0, 1'b1, 32'h100};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h108, 2, 1'b0, 1'b1, 32'h100};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h108, 1, 1'b1, 1'b1, 32'h104};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h108, 1, 1'b1, 1'b1, 32'h108};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h10c, 0, 1'b1, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h1f0, 1, 1'b1, 1'b1, 32'h1f0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h1f4, 2, 1'b0, 1'b1, 32'h1f0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h1f8, 0, 1'b1, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h200, 1, 1'b1, 1'b1, 32'h200};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h204, 0, 1'b1, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h208, 1, 1'b1, 1'b1, 32'h208};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h20c, 0, 1'b1, 1'b0, 32'h0};

        // Reset held two edges while dispatch offers an op
        rst = 1'b1;
        iv  = 1'b1;
        set_op(32'h8000_0000);
        repeat (2) @(posedge clk);
        #1;
        iv  = 1'b0;
        rst = 1'b0;
        chk("rst_o_valid", 64'(ovalid), 64'd0);
        chk("rst_count", 64'(ocount), 64'd0);
        chk("rst_i_ready", 64'(iready), 64'd1);
        chk_pl("rst_payload", cur_out(), '0);
        step();
        chk("rst_nothing_queued", 64'(ocount), 64'd0);

        // Single op held at the head until consumed
        set_op(32'h8000_0004);
        i_rs1   = 32'h5;
        i_rs2   = 32'hA;
        i_rdidx = 5'd3;
        iv      = 1'b1;
        ordy    = 1'b0;
        step();
        iv = 1'b0;
        chk("single_valid", 64'(ovalid), 64'd1);
        chk("single_count", 64'(ocount), 64'd1);
        chk("single_pc", 64'(o_pc), 64'h8000_0004);
        chk("single_rs1", 64'(o_rs1), 64'h5);
        chk("single_rs2", 64'(o_rs2), 64'hA);
        chk("single_rdidx", 64'(o_rdidx), 64'd3);
        hold_pc = o_pc;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("single_hold_pc", 64'(o_pc), 64'(hold_pc));
            chk("single_hold_valid", 64'(ovalid), 64'd1);
        end
        ordy = 1'b1;
        step();
        ordy = 1'b0;
        chk("single_pop_count", 64'(ocount), 64'd0);
        chk("single_pop_valid", 64'(ovalid), 64'd0);

        // Fill, backpressure, simultaneous push/pop, flush
        for (int i = 0; i < 13; i++) begin
            iv    = tbl[i].v;
            ordy  = tbl[i].ordy;
            flush = tbl[i].fl;
            set_op(tbl[i].pc);
            step();
            chk($sformatf("tbl%0d_count", i), 64'(ocount), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d_i_ready", i), 64'(iready), 64'(tbl[i].irdy));
            chk($sformatf("tbl%0d_o_valid", i), 64'(ovalid), 64'(tbl[i].ovld));
            if (tbl[i].ovld) chk($sformatf("tbl%0d_head_pc", i), 64'(o_pc), 64'(tbl[i].hpc));
        end
        iv    = 1'b0;
        ordy  = 1'b0;
        flush = 1'b0;
        step();

        // Streaming across pointer wraps
        p0 = pops;
        for (int i = 0; i < 16; i++) begin
            set_op(32'h1000 + 32'(4 * i));
            iv   = 1'b1;
            ordy = 1'b1;
            step();
            chk("stream_count", 64'(ocount), 64'd1);
            chk("stream_i_ready", 64'(iready), 64'd1);
            chk("stream_head_pc", 64'(o_pc), 64'(32'h1000 + 32'(4 * i)));
        end
        iv = 1'b0;
        step();
        ordy = 1'b0;
        chk("stream_drain_count", 64'(ocount), 64'd0);
        chk("stream_pops", 64'(pops - p0), 64'd16);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
